// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM responder: size encodings, FSM states,
// byte-lane decode and alignment helpers.
package data_ram_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StResp = 2'b10
   } state_e;

   // Low address bits forced to the natural alignment of the access size.
   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
      logic [1:0] res;
      case (size)
         SZ_BYTE: res = lo;
         SZ_HALF: res = {lo[1], 1'b0};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] res;
      case (size)
         SZ_BYTE: res = 4'b0001 << lo;
         SZ_HALF: res = lo[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic res;
      case (size)
         SZ_BYTE: res = 1'b0;
         SZ_HALF: res = lo[0];
         default: res = (lo != 2'b00);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_ram_bank.sv
// One byte-wide memory bank: synchronous write, combinational read, contents not reset.
module data_ram_bank #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [7:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_ram_responder.sv
// Word-organised data RAM answering MEM-stage loads/stores with req/ack and wait states.
// Define DATA_RAM_MISALIGN_TRAP_EN to flag misaligned half/word accesses on err.
module data_ram_responder
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        err
);

   localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [1:0]        lo_q, lo_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [3:0][7:0]   bank_rd;
   logic [3:0]        bank_we;
   logic [31:0]       wdata_st;
   logic [31:0]       shifted;
   logic [31:0]       load_data;
   logic [1:0]        eff_lo;
   logic [3:0]        mask;
   logic              fault;
   logic              wr_en;

   logic unused_addr;
   assign unused_addr = ^addr[31:ADDR_W+2];

`ifdef DATA_RAM_MISALIGN_TRAP_EN
   assign fault = misaligned(size_q, lo_q);
`else
   assign fault = 1'b0;
`endif

   assign eff_lo = align_lo(size_q, lo_q);
   assign mask   = lane_mask(size_q, eff_lo);

   // Replicate the right-justified store data so every lane sees its byte.
   always_comb begin
      case (size_q)
         SZ_BYTE: wdata_st = {4{wdata_q[7:0]}};
         SZ_HALF: wdata_st = {2{wdata_q[15:0]}};
         default: wdata_st = wdata_q;
      endcase
   end

   assign shifted = bank_rd >> {eff_lo, 3'b000};

   always_comb begin
      case (size_q)
         SZ_BYTE: load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // Stores commit on the edge that leaves RESP; an async reset clears state_q first.
   assign wr_en   = (state_q == StResp) && we_q && !fault;
   assign bank_we = {4{wr_en}} & mask;

   for (genvar i = 0; i < 4; i++) begin : g_bank
      data_ram_bank #(
         .ADDR_W(ADDR_W)
      ) u_bank (
         .clk_i  (clk),
         .we_i   (bank_we[i]),
         .addr_i (word_q),
         .wdata_i(wdata_st[8*i +: 8]),
         .rdata_o(bank_rd[i])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      word_d  = word_q;
      lo_d    = lo_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      err_d   = 1'b0;
      rdata_d = '0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               word_d  = addr[ADDR_W+1:2];
               lo_d    = addr[1:0];
               wdata_d = wdata;
               cnt_d   = WaitInit;
               busy_d  = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               ack_d   = 1'b1;
               err_d   = fault;
               rdata_d = (we_q || fault) ? 32'h0 : load_data;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sext_q  <= 1'b0;
         word_q  <= '0;
         lo_q    <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         word_q  <= word_d;
         lo_q    <= lo_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign ack   = ack_q;
   assign busy  = busy_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: one instance with zero wait states, one with three.
module tb_data_ram_responder;

   logic        clk = 1'b0;
   logic        rst0, rst3, req0, req3;
   logic        we, sext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        ack0, busy0, err0, ack3, busy3, err3;
   logic [31:0] rdata0, rdata3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0), .req(req0), .we(we), .size(size), .sext(sext), .addr(addr),
      .wdata(wdata), .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
   );

   data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .we(we), .size(size), .sext(sext), .addr(addr),
      .wdata(wdata), .ack(ack3), .rdata(rdata3), .busy(busy3), .err(err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int which, output logic a, output logic b, output logic [31:0] r,
                         output logic e);
      if (which == 0) begin
         a = ack0; b = busy0; r = rdata0; e = err0;
      end else begin
         a = ack3; b = busy3; r = rdata3; e = err3;
      end
   endtask

   // One complete transaction; inputs are scrambled right after capture to prove they are ignored.
   task automatic access(input string tag, input int which, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      logic        s_ack, s_busy, s_err, got_err;
      logic [31:0] s_rd, got_rd;
      int          lat, bcnt, exp_lat;
      bit          seen;
      exp_lat = (which == 0) ? 2 : 5;
      we = w; size = sz; sext = sx; addr = a; wdata = wd;
      if (which == 0) req0 = 1'b1; else req3 = 1'b1;
      lat = 0; bcnt = 0; seen = 0; got_rd = 32'h0; got_err = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         sample(which, s_ack, s_busy, s_rd, s_err);
         if (s_busy) bcnt++;
         if (s_ack) begin
            seen = 1; got_rd = s_rd; got_err = s_err;
         end
         if (i == 0) begin
            addr = a ^ 32'h4; wdata = ~wd; we = ~w;
         end
      end
      req0 = 1'b0; req3 = 1'b0;
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, bcnt, exp_lat);
      chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
      if (!w) chk({tag, "_rdata"}, got_rd, exp_rd);
      @(posedge clk); #1;
      sample(which, s_ack, s_busy, s_rd, s_err);
      chk({tag, "_ack_pulse"}, 32'(s_ack), 32'd0);
      chk({tag, "_busy_after"}, 32'(s_busy), 32'd0);
      chk({tag, "_rdata_idle"}, s_rd, 32'h0);
   endtask

   initial begin
      logic        s_ack, s_busy, s_err, got_ack;
      logic [31:0] s_rd, got_rd;
      int          lat, bcnt;
      bit          seen;

      rst0 = 1'b0; rst3 = 1'b0; req0 = 1'b0; req3 = 1'b0;
      we = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_err0", 32'(err0), 32'd0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_ack3", 32'(ack3), 32'd0);
      chk("rst_busy3", 32'(busy3), 32'd0);
      rst0 = 1'b1; rst3 = 1'b1;
      @(posedge clk); #1;

      // Zero wait states
      access("sw0", 0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 32'h0, 1'b0);
      access("lw0", 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 1'b0);
      access("lbu0_bank0", 0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0044, 1'b0);
      access("lbu3_bank3", 0, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0000_0011, 1'b0);
      access("lb1_sext", 0, 1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 32'h0000_0033, 1'b0);
      access("sb2", 0, 1'b1, 2'b00, 1'b0, 32'h2, 32'hFFFF_FFA5, 32'h0, 1'b0);
      access("lw0_after_sb", 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h11A5_3344, 1'b0);
      access("sh6", 0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_8000, 32'h0, 1'b0);
      access("lbu7_bank3", 0, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h0000_0080, 1'b0);
      access("lbu6_bank2", 0, 1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'h0000_0000, 1'b0);
      access("lh6_sext", 0, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF_8000, 1'b0);
      access("lhu6", 0, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h0000_8000, 1'b0);
      access("lb7_sext", 0, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0);
      access("lw_upper_ign", 0, 1'b0, 2'b10, 1'b0, 32'hFFFF_F000, 32'h0, 32'h11A5_3344, 1'b0);
      access("lw_rsvd_size", 0, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h11A5_3344, 1'b0);
`ifdef DATA_RAM_MISALIGN_TRAP_EN
      access("lw2_mis", 0, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
      access("sh1_mis", 0, 1'b1, 2'b01, 1'b0, 32'h1, 32'h0000_BEEF, 32'h0, 1'b1);
      access("lw0_after_sh1", 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h11A5_3344, 1'b0);
`else
      access("lw2_mask", 0, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h11A5_3344, 1'b0);
      access("sh1_mask", 0, 1'b1, 2'b01, 1'b0, 32'h1, 32'h0000_BEEF, 32'h0, 1'b0);
      access("lw0_after_sh1", 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h11A5_BEEF, 1'b0);
`endif

      // Three wait states
      access("sw8_w3", 3, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0102_0304, 32'h0, 1'b0);

      // Request held through ack: a second capture follows the IDLE cycle after RESP
      we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h8; wdata = 32'h0;
      req3 = 1'b1;
      lat = 0; bcnt = 0; seen = 0; got_rd = 32'h0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (busy3) bcnt++;
         if (ack3) begin
            seen = 1; got_rd = rdata3;
         end
      end
      chk("held_lat", lat, 5);
      chk("held_busy_cycles", bcnt, 5);
      chk("held_rdata", got_rd, 32'h0102_0304);
      @(posedge clk); #1;
      chk("held_idle_ack", 32'(ack3), 32'd0);
      chk("held_idle_busy", 32'(busy3), 32'd0);
      @(posedge clk); #1;
      chk("held_recapture_busy", 32'(busy3), 32'd1);
      lat = 0; seen = 0; got_rd = 32'h0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (ack3) begin
            seen = 1; got_rd = rdata3;
         end
      end
      req3 = 1'b0;
      chk("held2_lat", lat, 4);
      chk("held2_rdata", got_rd, 32'h0102_0304);
      @(posedge clk); #1;
      chk("held2_ack_pulse", 32'(ack3), 32'd0);

      // Reset while a store is waiting
      we = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'hDEAD_BEEF;
      req3 = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_busy_cap", 32'(busy3), 32'd1);
      @(posedge clk); #1;
      rst3 = 1'b0;
      #1;
      chk("rstmid_busy_async", 32'(busy3), 32'd0);
      req3 = 1'b0;
      got_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack3) got_ack = 1'b1;
         if (i == 2) rst3 = 1'b1;
      end
      chk("rstmid_no_ack", 32'(got_ack), 32'd0);
      access("lw8_after_rst", 3, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0102_0304, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
